// File: rtl/id_decode_stage.sv
// ID stage for ARM data-processing instructions: splits fields for the EX ALU and
// shifter, evaluates the condition code and owns the NZCV status register.
module id_decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [3:0]  ex_flags_in,
  input  logic        ex_s_in,
  output logic        valid_out,
  output logic [3:0]  alu_op,
  output logic        s_out,
  output logic [2:0]  i_cmd,
  output logic [11:0] shift_field,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [3:0]  rm,
  output logic        rf_we,
  output logic [3:0]  flags_out
);

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic        s;
    logic [2:0]  i_cmd;
    logic [11:0] shift_field;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic        rf_we;
  } idex_t;

  logic [3:0] flags_q, flags_d;
  idex_t      idex_q, idex_d, decoded;
  cond_e      cond;
  logic       cond_pass;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       accept;

  // The next status value doubles as the bypassed flags for the condition check.
  assign flags_d = ex_s_in ? ex_flags_in : flags_q;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_d;
  assign cond = cond_e'(instr_in[31:28]);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      COND_EQ: cond_pass = flag_z;
      COND_NE: cond_pass = !flag_z;
      COND_CS: cond_pass = flag_c;
      COND_CC: cond_pass = !flag_c;
      COND_MI: cond_pass = flag_n;
      COND_PL: cond_pass = !flag_n;
      COND_VS: cond_pass = flag_v;
      COND_VC: cond_pass = !flag_v;
      COND_HI: cond_pass = flag_c && !flag_z;
      COND_LS: cond_pass = !flag_c || flag_z;
      COND_GE: cond_pass = (flag_n == flag_v);
      COND_LT: cond_pass = (flag_n != flag_v);
      COND_GT: cond_pass = !flag_z && (flag_n == flag_v);
      COND_LE: cond_pass = flag_z || (flag_n != flag_v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Register-shifted-register operands (I=0, bit4=1) are not supported.
  assign accept = instr_valid && cond_pass && (instr_in[27:26] == 2'b00)
                  && !(!instr_in[25] && instr_in[4]);

  always_comb begin
    decoded = '0;
    if (accept) begin
      decoded.valid       = 1'b1;
      decoded.alu_op      = instr_in[24:21];
      decoded.s           = instr_in[20];
      decoded.i_cmd       = instr_in[27:25];
      decoded.shift_field = instr_in[11:0];
      decoded.rn          = instr_in[19:16];
      decoded.rd          = instr_in[15:12];
      decoded.rm          = instr_in[3:0];
      // Compare/test opcodes 8..11 only produce flags.
      decoded.rf_we       = (instr_in[24:23] != 2'b10);
    end
  end

  always_comb begin
    idex_d = decoded;
    if (flush)      idex_d = '0;
    else if (stall) idex_d = idex_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q  <= '0;
      flags_q <= '0;
    end else begin
      idex_q  <= idex_d;
      flags_q <= flags_d;
    end
  end

  assign valid_out   = idex_q.valid;
  assign alu_op      = idex_q.alu_op;
  assign s_out       = idex_q.s;
  assign i_cmd       = idex_q.i_cmd;
  assign shift_field = idex_q.shift_field;
  assign rn          = idex_q.rn;
  assign rd          = idex_q.rd;
  assign rm          = idex_q.rm;
  assign rf_we       = idex_q.rf_we;
  assign flags_out   = flags_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: a reference model pushes expected
// outputs to a scoreboard when stimulus is driven; they are popped after the edge.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid, stall, flush, ex_s_in;
  logic [3:0]  ex_flags_in;
  logic        valid_out, s_out, rf_we;
  logic [3:0]  alu_op, rn, rd, rm, flags_out;
  logic [2:0]  i_cmd;
  logic [11:0] shift_field;

  id_decode_stage dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .ex_flags_in(ex_flags_in), .ex_s_in(ex_s_in),
    .valid_out(valid_out), .alu_op(alu_op), .s_out(s_out), .i_cmd(i_cmd),
    .shift_field(shift_field), .rn(rn), .rd(rd), .rm(rm), .rf_we(rf_we),
    .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [33:0] outs;  // {valid, alu_op, s, i_cmd, shift_field, rn, rd, rm, rf_we}
    logic [3:0]  flags;
  } exp_t;

  exp_t        sb[$];
  logic [33:0] m_outs;
  logic [3:0]  m_flags;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [31:0] ADDS   = 32'hE2921005;
  localparam logic [31:0] CMP    = 32'hE1530004;
  localparam logic [31:0] MOVEQ  = 32'h03A00001;
  localparam logic [31:0] RSR    = 32'hE0821312;
  localparam logic [31:0] NV_ADD = 32'hF2921005;
  localparam logic [31:0] LDR    = 32'hE5912000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy & !z;
      4'd9:  return !cy | z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z & (n == v);
      4'd13: return z | (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [33:0] model_decode(input logic [31:0] ins, input logic v,
                                               input logic [3:0] f);
    logic [3:0] op;
    logic       ok;
    op = ins[24:21];
    ok = v && cond_ok(ins[31:28], f) && ins[27:26] == 2'b00 && !(ins[25] == 1'b0 && ins[4] == 1'b1);
    if (!ok) return '0;
    return {1'b1, op, ins[20], ins[27:25], ins[11:0], ins[19:16], ins[15:12], ins[3:0],
            !(op >= 4'd8 && op <= 4'd11)};
  endfunction

  task automatic step(input string tag, input logic rst, input logic [31:0] ins,
                      input logic v, input logic st, input logic fl,
                      input logic es, input logic [3:0] ef);
    exp_t e;
    exp_t got;
    logic [3:0] eff;
    reset = rst; instr_in = ins; instr_valid = v; stall = st; flush = fl;
    ex_s_in = es; ex_flags_in = ef;
    eff = es ? ef : m_flags;
    if (rst) begin
      m_outs = '0; m_flags = '0;
    end else begin
      if (fl)       m_outs = '0;
      else if (!st) m_outs = model_decode(ins, v, eff);
      m_flags = eff;
    end
    e.outs = m_outs; e.flags = m_flags;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got.outs  = {valid_out, alu_op, s_out, i_cmd, shift_field, rn, rd, rm, rf_we};
    got.flags = flags_out;
    e = sb.pop_front();
    check({tag, ".outs"}, 64'(got.outs), 64'(e.outs));
    check({tag, ".flags"}, 64'(got.flags), 64'(e.flags));
  endtask

  initial begin
    reset = 1'b1; instr_in = '0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    ex_s_in = 1'b0; ex_flags_in = '0;
    m_outs = '0; m_flags = '0;
    @(negedge clk);

    step("reset", 1, ADDS, 1, 0, 0, 0, 4'h0);
    check("reset.valid", 64'(valid_out), 64'd0);
    check("reset.flags_out", 64'(flags_out), 64'd0);

    step("adds", 0, ADDS, 1, 0, 0, 0, 4'h0);
    check("adds.fields", 64'({valid_out, alu_op, s_out, i_cmd, rn, rd, shift_field, rf_we}),
          64'({1'b1, 4'b0100, 1'b1, 3'b001, 4'd2, 4'd1, 12'h005, 1'b1}));

    step("cmp", 0, CMP, 1, 0, 0, 0, 4'h0);
    check("cmp.fields", 64'({valid_out, alu_op, s_out, i_cmd, rn, rm, rf_we}),
          64'({1'b1, 4'b1010, 1'b1, 3'b000, 4'd3, 4'd4, 1'b0}));

    // Flag bypass and registered-flag paths for MOVEQ.
    step("moveq_bypass", 0, MOVEQ, 1, 0, 0, 1, 4'b0100);
    check("moveq_bypass.op", 64'({valid_out, alu_op}), 64'({1'b1, 4'b1101}));
    step("moveq_reg", 0, MOVEQ, 1, 0, 0, 0, 4'h0);
    check("moveq_reg.valid", 64'(valid_out), 64'd1);
    step("moveq_bypass_clear", 0, MOVEQ, 1, 0, 0, 1, 4'b0000);
    check("moveq_bypass_clear.valid", 64'(valid_out), 64'd0);
    step("moveq_reg_clear", 0, MOVEQ, 1, 0, 0, 0, 4'h0);
    check("moveq_reg_clear.valid", 64'(valid_out), 64'd0);

    // Stall for three cycles with a flag write in the middle.
    step("pre_stall", 0, ADDS, 1, 0, 0, 0, 4'h0);
    step("stall1", 0, CMP, 1, 1, 0, 0, 4'h0);
    step("stall2", 0, MOVEQ, 1, 1, 0, 1, 4'b1000);
    check("stall2.flags_out", 64'(flags_out), 64'b1000);
    step("stall3", 0, RSR, 1, 1, 0, 0, 4'h0);
    check("stall3.frozen", 64'({valid_out, alu_op, rn, rd, shift_field}),
          64'({1'b1, 4'b0100, 4'd2, 4'd1, 12'h005}));
    step("unstall", 0, CMP, 1, 0, 0, 0, 4'h0);

    step("stall_flush", 0, ADDS, 1, 1, 1, 1, 4'b0110);
    check("stall_flush.bubble", 64'({valid_out, rf_we, s_out, flags_out}),
          64'({3'b000, 4'b0110}));
    step("nv_cond", 0, NV_ADD, 1, 0, 0, 0, 4'h0);
    check("nv_cond.valid", 64'(valid_out), 64'd0);
    step("reg_shift_reg", 0, RSR, 1, 0, 0, 0, 4'h0);
    check("reg_shift_reg.valid", 64'(valid_out), 64'd0);
    step("ldr_class", 0, LDR, 1, 0, 0, 0, 4'h0);
    step("not_valid", 0, ADDS, 0, 0, 0, 0, 4'h0);

    // Every condition code against every flag value, via bypass or via the register.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        logic [31:0] ins;
        ins = {c[3:0], 28'h0821003};
        if (((c + f) & 1) == 1) begin
          step("cond_bypass", 0, ins, 1, 0, 0, 1, f[3:0]);
        end else begin
          step("cond_load", 0, 32'h0, 0, 0, 0, 1, f[3:0]);
          step("cond_reg", 0, ins, 1, 0, 0, 0, 4'h0);
        end
      end
    end

    // Reset mid-stream overrides stall and a flag write.
    step("load_1111", 0, ADDS, 1, 0, 0, 1, 4'b1111);
    check("load_1111.state", 64'({valid_out, flags_out}), 64'({1'b1, 4'b1111}));
    step("reset_mid", 1, ADDS, 1, 1, 0, 1, 4'b0101);
    check("reset_mid.all", 64'({valid_out, alu_op, s_out, i_cmd, shift_field, rn, rd, rm, rf_we, flags_out}),
          64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Registered decode stage that sits directly upstream of the EX-stage ALU and shifter/sign-extender. It splits each ARM data-processing instruction into the control fields those blocks consume: ALU opcode, S bit, shifter command and 12-bit shifter field, plus register addresses. It also owns the NZCV status register written back from EX, and evaluates each instruction's condition field against that register. The ID/EX pipeline register with stall and flush lives here.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instr_in  in  32  instruction word from fetch
- instr_valid  in  1  instr_in holds a real instruction
- stall  in  1  hold ID/EX register
- flush  in  1  replace next ID/EX contents with a bubble
- ex_flags_in  in  4  {N,Z,C,V} produced by EX this cycle
- ex_s_in  in  1  EX commits ex_flags_in this cycle
- valid_out  out  1  ID/EX slot holds an executable instruction
- alu_op  out  4  instr[24:21], in ALU opcode encoding
- s_out  out  1  instr[20]
- i_cmd  out  3  instr[27:25]
- shift_field  out  12  instr[11:0]
- rn, rd, rm  out  4 each  instr[19:16], [15:12], [3:0]
- rf_we  out  1  write Rd in writeback
- flags_out  out  4  current status register {N,Z,C,V}; flags_out[1] is ALU carry-in

## Operation
- Reset applies when reset=1 at a clk edge. Every output and the status register go to 0, so valid_out=0 and flags_out=4'b0000.
- Status register: it loads ex_flags_in at the clock edge when ex_s_in=1, and otherwise holds.
- Effective flags: use ex_flags_in if ex_s_in=1 this cycle, else the status register. This bypass covers a flag-setting instruction that is in EX while its dependant is in decode.
- Condition pass uses the effective flags, with cond=instr_in[31:28]:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL 1, 4'b1111 0
- An instruction is accepted when instr_valid=1, cond passes, instr_in[27:26]=2'b00, and it is not the register-shifted-register form (instr_in[25]=0 and instr_in[4]=1 is unsupported).
- Accepted instruction: load all field outputs as listed and set valid_out=1.
  - rf_we=1 unless alu_op is in 4'b1000–4'b1011 (TST/TEQ/CMP/CMN).
- Non-accepted instruction: bubble. valid_out=0, s_out=0, rf_we=0, and alu_op/i_cmd/shift_field/rn/rd/rm=0.
- Priority at each edge: reset > flush > stall > normal load.
  - Flush forces a bubble, even if stall=1.
  - Stall holds every ID/EX output unchanged.
- The status register update is independent of stall and flush and is blocked only by reset.

## Timing
- Latency is 1 cycle: instr_in sampled at edge k appears on the outputs after edge k.
- Condition evaluation happens at the capturing edge only. During a stall, the held output is not re-evaluated. When stall drops, the instruction then on instr_in is evaluated with the flags current at that edge.
- Bypass: if ex_s_in=1 in the same cycle the dependant is sampled, the decision uses ex_flags_in, not the stale register.
- flags_out changes the cycle after an ex_s_in edge.
- Reset asserted mid-stream: the next edge yields a bubble and flags 0000, regardless of stall, flush or ex_s_in.
- Flush and ex_s_in in the same cycle: the output is a bubble and the flags still update.

## Test plan
- Reset, then instr_in=32'hE2921005 (ADDS R1,R2,#5), instr_valid=1 → next cycle:
  - valid_out=1, alu_op=4'b0100, s_out=1, i_cmd=3'b001
  - rn=2, rd=1, shift_field=12'h005, rf_we=1
- instr_in=32'hE1530004 (CMP R3,R4) → valid_out=1, alu_op=4'b1010, s_out=1, i_cmd=3'b000, rn=3, rm=4, rf_we=0.
- Flag bypass, with status register at 0000:
  - Cycle 1: ex_s_in=1, ex_flags_in=4'b0100, and instr_in=32'h03A00001 (MOVEQ R0,#1) → accepted, valid_out=1, alu_op=4'b1101.
  - Same instruction one cycle later with ex_s_in=0 and register=0100 → accepted.
  - Same instruction with register=0000 and no bypass → bubble.
- Stall held 3 cycles with instr_in changing each cycle → outputs frozen at the pre-stall instruction. During the stall, ex_s_in=1 with 4'b1000 → flags_out=4'b1000 one cycle later.
- stall=1 and flush=1 together → bubble (valid_out=0, rf_we=0, s_out=0). A cond=4'b1111 instruction, or 32'hE0821312 (register-shifted form) → bubble.
- Reset asserted while valid_out=1 and flags_out=4'b1111 → after one edge, all outputs are 0 and flags_out=4'b0000.
